// File: rtl/conv2d_event_accumulator_if.sv
// Event, kernel-weight and feature-map ports of conv2d_event_accumulator.
// The engine uses the slave view; the event source and memories use the master view.
interface conv2d_event_accumulator_if #(
    parameter int COORD_BITS   = 8,
    parameter int IN_CHANNELS  = 2,
    parameter int OUT_CHANNELS = 4,
    parameter int NEURON_BITS  = 8,
    parameter int WEIGHT_BITS  = 4,
    parameter int KERNEL_SIZE  = 3
);
    localparam int KW_ADDR_BITS = (IN_CHANNELS * KERNEL_SIZE * KERNEL_SIZE > 1) ?
                                  $clog2(IN_CHANNELS * KERNEL_SIZE * KERNEL_SIZE) : 1;

    logic                                  ev_valid;
    logic                                  ev_ready;
    logic [COORD_BITS-1:0]                 ev_x;
    logic [COORD_BITS-1:0]                 ev_y;
    logic [IN_CHANNELS-1:0]                ev_spikes;
    logic                                  busy;
    logic                                  kw_en;
    logic [KW_ADDR_BITS-1:0]               kw_addr;
    logic [OUT_CHANNELS*WEIGHT_BITS-1:0]   kw_data;
    logic                                  fm_rd_en;
    logic [COORD_BITS-1:0]                 fm_rd_x;
    logic [COORD_BITS-1:0]                 fm_rd_y;
    logic [OUT_CHANNELS*NEURON_BITS-1:0]   fm_rd_data;
    logic                                  fm_wr_en;
    logic [COORD_BITS-1:0]                 fm_wr_x;
    logic [COORD_BITS-1:0]                 fm_wr_y;
    logic [OUT_CHANNELS*NEURON_BITS-1:0]   fm_wr_data;
    logic                                  fm_grant;

    modport slave (
        input  ev_valid, ev_x, ev_y, ev_spikes, kw_data, fm_rd_data, fm_grant,
        output ev_ready, busy, kw_en, kw_addr, fm_rd_en, fm_rd_x, fm_rd_y,
               fm_wr_en, fm_wr_x, fm_wr_y, fm_wr_data
    );

    modport master (
        output ev_valid, ev_x, ev_y, ev_spikes, kw_data, fm_rd_data, fm_grant,
        input  ev_ready, busy, kw_en, kw_addr, fm_rd_en, fm_rd_x, fm_rd_y,
               fm_wr_en, fm_wr_x, fm_wr_y, fm_wr_data
    );
endinterface

// File: rtl/conv2d_event_accumulator.sv
// Event-driven 2-D convolution: one read-modify-write per in-bounds kernel position, summing
// the weights of every spiking input channel. Define CONV_SATURATE_EN to clamp instead of wrap.
module conv2d_event_accumulator #(
    parameter int COORD_BITS   = 8,
    parameter int IN_CHANNELS  = 2,
    parameter int OUT_CHANNELS = 4,
    parameter int IMG_WIDTH    = 32,
    parameter int IMG_HEIGHT   = 32,
    parameter int NEURON_BITS  = 8,
    parameter int WEIGHT_BITS  = 4,
    parameter int KERNEL_SIZE  = 3
) (
    input  logic clk,
    input  logic rst_n,
    conv2d_event_accumulator_if.slave bus
);
    localparam int KO  = KERNEL_SIZE / 2;
    localparam int K2  = KERNEL_SIZE * KERNEL_SIZE;
    localparam int KWA = (IN_CHANNELS * K2 > 1) ? $clog2(IN_CHANNELS * K2) : 1;
    localparam int CHW = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
    localparam int SW  = $clog2(IN_CHANNELS + 1);
    localparam int KB  = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
    localparam int AW  = NEURON_BITS + $clog2(IN_CHANNELS) + 2;
    localparam int FW  = OUT_CHANNELS * NEURON_BITS;
    localparam int NB  = NEURON_BITS;
    localparam int WB  = WEIGHT_BITS;
`ifdef CONV_SATURATE_EN
    localparam logic signed [AW-1:0] SMAX = AW'(2 ** (NEURON_BITS - 1) - 1);
    localparam logic signed [AW-1:0] SMIN = ~SMAX;
`endif

    typedef enum logic [1:0] {IDLE, PREP, RUN, DONE} state_t;
    state_t state_r, state_n;

    logic [COORD_BITS-1:0]  x_r, y_r;
    logic [IN_CHANNELS-1:0] spk_r;
    logic [CHW-1:0]         list_r [IN_CHANNELS];
    logic [CHW-1:0]         list_c [IN_CHANNELS];
    logic [SW-1:0]          n_r, n_c, step_r;
    logic [KB-1:0]          dx_r, dy_r;
    logic [FW-1:0]          fm_r, fm_cur, wr_data_c, hold_data_r;
    logic                   hold_r;
    logic signed [AW-1:0]   acc_r [OUT_CHANNELS];
    logic signed [AW-1:0]   sum;
    logic [CHW-1:0]         ch_sel;
    int                     tx, ty;
    int unsigned            cnt;
    logic                   inb, last_pos, rd_c, wr_c, kw_c, stall, advance;

    // Ascending list of spiking channel indices, latched in PREP.
    always_comb begin
        cnt = 0;
        for (int unsigned j = 0; j < IN_CHANNELS; j++) list_c[j] = '0;
        for (int unsigned i = 0; i < IN_CHANNELS; i++) begin
            if (spk_r[i]) begin
                for (int unsigned j = 0; j < IN_CHANNELS; j++)
                    if (j == cnt) list_c[j] = CHW'(i);
                cnt = cnt + 1;
            end
        end
        n_c = SW'(cnt);
    end

    always_comb begin
        tx       = int'(x_r) + int'(dx_r) - KO;
        ty       = int'(y_r) + int'(dy_r) - KO;
        inb      = (tx >= 0) && (tx < IMG_WIDTH) && (ty >= 0) && (ty < IMG_HEIGHT);
        last_pos = (dx_r == KB'(KERNEL_SIZE - 1)) && (dy_r == KB'(KERNEL_SIZE - 1));
        ch_sel   = '0;
        for (int unsigned i = 0; i < IN_CHANNELS; i++)
            if (SW'(i) == step_r) ch_sel = list_r[i];
        // fm_rd_data is only live in step 1; later steps use the registered copy.
        fm_cur    = (step_r == SW'(1)) ? bus.fm_rd_data : fm_r;
        wr_data_c = '0;
        sum       = '0;
        for (int unsigned c = 0; c < OUT_CHANNELS; c++) begin
            sum = AW'($signed(fm_cur[c*NB +: NB])) + acc_r[c]
                + AW'($signed(bus.kw_data[c*WB +: WB]));
`ifdef CONV_SATURATE_EN
            if (sum > SMAX)      wr_data_c[c*NB +: NB] = SMAX[NB-1:0];
            else if (sum < SMIN) wr_data_c[c*NB +: NB] = SMIN[NB-1:0];
            else                 wr_data_c[c*NB +: NB] = sum[NB-1:0];
`else
            wr_data_c[c*NB +: NB] = sum[NB-1:0];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_n;
    end

    always_comb begin
        state_n = state_r;
        rd_c    = 1'b0;
        wr_c    = 1'b0;
        kw_c    = 1'b0;
        stall   = 1'b0;
        advance = 1'b0;
        case (state_r)
            IDLE: if (bus.ev_valid) state_n = PREP;
            PREP: state_n = (n_c == '0) ? DONE : RUN;
            RUN: begin
                if (inb) begin
                    if (step_r == '0) begin
                        rd_c = 1'b1;
                        kw_c = 1'b1;
                    end else if (step_r < n_r) begin
                        kw_c = 1'b1;
                    end else begin
                        wr_c = 1'b1;
                    end
                end
                stall   = !bus.fm_grant && (rd_c || wr_c);
                advance = !stall && (!inb || step_r == n_r);
                if (advance && last_pos) state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        bus.ev_ready   = (state_r == IDLE);
        bus.busy       = (state_r != IDLE);
        bus.kw_en      = kw_c;
        bus.kw_addr    = kw_c ? KWA'(int'(ch_sel) * K2 + int'(dy_r) * KERNEL_SIZE + int'(dx_r)) : '0;
        bus.fm_rd_en   = rd_c;
        bus.fm_rd_x    = rd_c ? COORD_BITS'(tx) : '0;
        bus.fm_rd_y    = rd_c ? COORD_BITS'(ty) : '0;
        bus.fm_wr_en   = wr_c;
        bus.fm_wr_x    = wr_c ? COORD_BITS'(tx) : '0;
        bus.fm_wr_y    = wr_c ? COORD_BITS'(ty) : '0;
        bus.fm_wr_data = wr_c ? (hold_r ? hold_data_r : wr_data_c) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r         <= '0;
            y_r         <= '0;
            spk_r       <= '0;
            n_r         <= '0;
            step_r      <= '0;
            dx_r        <= '0;
            dy_r        <= '0;
            fm_r        <= '0;
            hold_r      <= 1'b0;
            hold_data_r <= '0;
            for (int unsigned i = 0; i < IN_CHANNELS; i++) list_r[i] <= '0;
            for (int unsigned c = 0; c < OUT_CHANNELS; c++) acc_r[c] <= '0;
        end else begin
            case (state_r)
                IDLE: if (bus.ev_valid) begin
                    x_r   <= bus.ev_x;
                    y_r   <= bus.ev_y;
                    spk_r <= bus.ev_spikes;
                end
                PREP: begin
                    for (int unsigned i = 0; i < IN_CHANNELS; i++) list_r[i] <= list_c[i];
                    for (int unsigned c = 0; c < OUT_CHANNELS; c++) acc_r[c] <= '0;
                    n_r    <= n_c;
                    step_r <= '0;
                    dx_r   <= '0;
                    dy_r   <= '0;
                    hold_r <= 1'b0;
                end
                RUN: begin
                    if (advance) begin
                        for (int unsigned c = 0; c < OUT_CHANNELS; c++) acc_r[c] <= '0;
                        step_r <= '0;
                        hold_r <= 1'b0;
                        if (dx_r == KB'(KERNEL_SIZE - 1)) begin
                            dx_r <= '0;
                            dy_r <= dy_r + KB'(1);
                        end else begin
                            dx_r <= dx_r + KB'(1);
                        end
                    end else if (stall) begin
                        // Freeze the write word on the first stalled cycle; its sources may not hold.
                        if (wr_c && !hold_r) begin
                            hold_r      <= 1'b1;
                            hold_data_r <= wr_data_c;
                        end
                    end else begin
                        step_r <= step_r + SW'(1);
                        if (step_r == SW'(1)) fm_r <= bus.fm_rd_data;
                        if (step_r != '0)
                            for (int unsigned c = 0; c < OUT_CHANNELS; c++)
                                acc_r[c] <= acc_r[c] + AW'($signed(bus.kw_data[c*WB +: WB]));
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
